lcd_byte_writer: RTL and testbench

- Output stage directly downstream of the mini ALU LED latch.
- Takes one byte (data or command) per valid/ready handshake and drives the Spartan-3E 4-bit character-LCD bus.
- Sends the high nibble then the low nibble, each with setup, enable pulse and hold timing counted in Clock cycles.
- Drops oReady while a transfer is in progress, so the ALU side stalls LED-style writes until the LCD can accept another.

---
 rtl/lcd_byte_writer.sv | 184 ++++++++++++++++++
 tb/tb_lcd_byte_writer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_byte_writer.sv
// Byte-to-nibble writer for the 4-bit character-LCD bus with E strobe timing.
// Define LCD_INIT_EN to add the power-on 0x3,0x3,0x3,0x2 init sequence.
module lcd_byte_writer #(
    parameter int SETUP_CYC      = 2,
    parameter int PULSE_CYC      = 12,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int BYTE_WAIT_CYC  = 2000,
`ifdef LCD_INIT_EN
    parameter int INIT_WAIT_CYC  = 750000,
`endif
    parameter int CNT_W          = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    localparam int S_N = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int P_N = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
    localparam int G_N = (NIBBLE_GAP_CYC < 1) ? 1 : NIBBLE_GAP_CYC;
    localparam int W_N = (BYTE_WAIT_CYC < 1) ? 1 : BYTE_WAIT_CYC;

    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(S_N - 1);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P_N - 1);
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(G_N - 1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_N - 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] HI_SETUP = 4'd1;
    localparam logic [3:0] HI_PULSE = 4'd2;
    localparam logic [3:0] HI_GAP   = 4'd3;
    localparam logic [3:0] LO_SETUP = 4'd4;
    localparam logic [3:0] LO_PULSE = 4'd5;
    localparam logic [3:0] LO_WAIT  = 4'd6;
`ifdef LCD_INIT_EN
    localparam logic [3:0] INIT_WAIT  = 4'd7;
    localparam logic [3:0] INIT_SETUP = 4'd8;
    localparam logic [3:0] INIT_PULSE = 4'd9;
    localparam logic [3:0] INIT_HOLD  = 4'd10;
    localparam int I_N = (INIT_WAIT_CYC < 1) ? 1 : INIT_WAIT_CYC;
    localparam logic [CNT_W-1:0] I_LAST = CNT_W'(I_N - 1);
    localparam logic [3:0] RST_STATE = INIT_WAIT;
    localparam logic       RST_READY = 1'b0;
`else
    localparam logic [3:0] RST_STATE = IDLE;
    localparam logic       RST_READY = 1'b1;
`endif

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [3:0]       data_q, data_d;
    logic [3:0]       lo_q, lo_d;
`ifdef LCD_INIT_EN
    logic [1:0]       idx_q, idx_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        rs_d    = rs_q;
        data_d  = data_q;
        lo_d    = lo_q;
`ifdef LCD_INIT_EN
        idx_d   = idx_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (iValid && ready_q) begin
                    state_d = HI_SETUP;
                    rs_d    = iRS;
                    data_d  = iData[7:4];
                    lo_d    = iData[3:0];
                end
            end
            HI_SETUP: if (cnt_q == S_LAST) begin
                state_d = HI_PULSE;
                cnt_d   = '0;
            end
            HI_PULSE: if (cnt_q == P_LAST) begin
                state_d = HI_GAP;
                cnt_d   = '0;
            end
            HI_GAP: begin
                // switch one edge after E falls to keep hold time on DB7..DB4
                if (cnt_q == '0) data_d = lo_q;
                if (cnt_q == G_LAST) begin
                    state_d = LO_SETUP;
                    cnt_d   = '0;
                end
            end
            LO_SETUP: if (cnt_q == S_LAST) begin
                state_d = LO_PULSE;
                cnt_d   = '0;
            end
            LO_PULSE: if (cnt_q == P_LAST) begin
                state_d = LO_WAIT;
                cnt_d   = '0;
            end
            LO_WAIT: if (cnt_q == W_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
`ifdef LCD_INIT_EN
            INIT_WAIT: if (cnt_q == I_LAST) begin
                state_d = INIT_SETUP;
                cnt_d   = '0;
                rs_d    = 1'b0;
                data_d  = 4'h3;
            end
            INIT_SETUP: if (cnt_q == S_LAST) begin
                state_d = INIT_PULSE;
                cnt_d   = '0;
            end
            INIT_PULSE: if (cnt_q == P_LAST) begin
                state_d = INIT_HOLD;
                cnt_d   = '0;
            end
            INIT_HOLD: if (cnt_q == W_LAST) begin
                cnt_d = '0;
                if (idx_q == 2'd3) begin
                    state_d = IDLE;
                end else begin
                    state_d = INIT_SETUP;
                    idx_d   = idx_q + 2'd1;
                    data_d  = (idx_q == 2'd2) ? 4'h2 : 4'h3;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d == IDLE);
        e_d     = (state_d == HI_PULSE) || (state_d == LO_PULSE);
`ifdef LCD_INIT_EN
        e_d     = e_d || (state_d == INIT_PULSE);
`endif
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ready_q <= RST_READY;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 4'h0;
            lo_q    <= 4'h0;
`ifdef LCD_INIT_EN
            idx_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
`ifdef LCD_INIT_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign oReady    = ready_q;
    assign oLCD_E    = e_q;
    assign oLCD_RS   = rs_q;
    assign oLCD_RW   = 1'b0;
    assign oLCD_Data = data_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer with 2/4/3/5 cycle timing.
// Per-cycle byte profile table plus reset, back-to-back and scoreboard runs.
module tb_lcd_byte_writer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_Data;

    always #5 Clock = ~Clock;

    lcd_byte_writer #(
        .SETUP_CYC(2),
        .PULSE_CYC(4),
        .NIBBLE_GAP_CYC(3),
        .BYTE_WAIT_CYC(5),
`ifdef LCD_INIT_EN
        .INIT_WAIT_CYC(10),
`endif
        .CNT_W(20)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iData(iData),
        .iRS(iRS),
        .iValid(iValid),
        .oReady(oReady),
        .oLCD_E(oLCD_E),
        .oLCD_RS(oLCD_RS),
        .oLCD_RW(oLCD_RW),
        .oLCD_Data(oLCD_Data)
    );

    // dsel: 0 = data not checked, 1 = high nibble, 2 = low nibble
    typedef struct {
        int   first;
        int   last;
        logic e;
        int   dsel;
        logic rdy;
    } seg_t;

    seg_t segs[7];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   mon_en = 0;
    int   rw_bad = 0;
    logic [3:0] nib_q[$];
    logic       nrs_q[$];
    logic [7:0] exp_b[$];
    logic       exp_rs[$];

    always @(negedge oLCD_E) begin
        if (mon_en) begin
            nib_q.push_back(oLCD_Data);
            nrs_q.push_back(oLCD_RS);
        end
    end

    always @(negedge Clock) begin
        if (mon_en && oLCD_RW !== 1'b0) rw_bad++;
    end

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic send_chk(input logic [7:0] b, input logic rs,
                            input bit glitch, input bit keep);
        logic [3:0] ed;
        bit ok;
        iData  = b;
        iRS    = rs;
        iValid = 1'b1;
        check("accept_ready", oReady === 1'b1, {31'd0, oReady}, 32'd1);
        @(posedge Clock);
        #1;
        if (!keep) iValid = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge Clock);
            for (int s = 0; s < 7; s++) begin
                if (k >= segs[s].first && k <= segs[s].last) begin
                    ed = (segs[s].dsel == 1) ? b[7:4] : b[3:0];
                    ok = (oLCD_E === segs[s].e) && (oReady === segs[s].rdy) &&
                         (oLCD_RS === rs) && (oLCD_RW === 1'b0) &&
                         (segs[s].dsel == 0 || oLCD_Data === ed);
                    check($sformatf("byte_%h_k%0d", b, k), ok,
                          {24'd0, oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data},
                          {24'd0, segs[s].rdy, segs[s].e, rs, 1'b0, ed});
                end
            end
            if (glitch && k == 3) begin
                iData  = 8'hFF;
                iValid = 1'b1;
            end
            if (glitch && k == 4) iValid = 1'b0;
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (oReady !== 1'b1 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (oReady !== 1'b1) check(name, 1'b0, {31'd0, oReady}, 32'd1);
    endtask

    task automatic send_raw(input logic [7:0] b, input logic rs);
        wait_ready("raw_wait_idle");
        iData  = b;
        iRS    = rs;
        iValid = 1'b1;
        @(posedge Clock);
        #1;
        iValid = 1'b0;
        exp_b.push_back(b);
        exp_rs.push_back(rs);
        @(negedge Clock);
        wait_ready("raw_timeout");
    endtask

    initial begin
        segs[0] = '{0, 1, 1'b0, 1, 1'b0};
        segs[1] = '{2, 5, 1'b1, 1, 1'b0};
        segs[2] = '{6, 8, 1'b0, 0, 1'b0};
        segs[3] = '{9, 10, 1'b0, 2, 1'b0};
        segs[4] = '{11, 14, 1'b1, 2, 1'b0};
        segs[5] = '{15, 19, 1'b0, 2, 1'b0};
        segs[6] = '{20, 20, 1'b0, 2, 1'b1};

        #12;
        check("rst_e", oLCD_E === 1'b0, {31'd0, oLCD_E}, 32'd0);
        check("rst_rs", oLCD_RS === 1'b0, {31'd0, oLCD_RS}, 32'd0);
        check("rst_rw", oLCD_RW === 1'b0, {31'd0, oLCD_RW}, 32'd0);
        check("rst_data", oLCD_Data === 4'h0, {28'd0, oLCD_Data}, 32'd0);
`ifdef LCD_INIT_EN
        check("rst_ready", oReady === 1'b0, {31'd0, oReady}, 32'd0);
        mon_en = 1;
        @(negedge Clock);
        Reset = 1'b1;
        begin
            int n = 0;
            while (oReady !== 1'b1 && n < 200) begin
                @(negedge Clock);
                n++;
            end
            check("init_len", n == 54, n, 54);
        end
        mon_en = 0;
        check("init_pulses", nib_q.size() == 4, nib_q.size(), 4);
        if (nib_q.size() == 4) begin
            check("init_n0", nib_q[0] == 4'h3 && nrs_q[0] == 1'b0,
                  {nrs_q[0], nib_q[0]}, 5'h03);
            check("init_n1", nib_q[1] == 4'h3 && nrs_q[1] == 1'b0,
                  {nrs_q[1], nib_q[1]}, 5'h03);
            check("init_n2", nib_q[2] == 4'h3 && nrs_q[2] == 1'b0,
                  {nrs_q[2], nib_q[2]}, 5'h03);
            check("init_n3", nib_q[3] == 4'h2 && nrs_q[3] == 1'b0,
                  {nrs_q[3], nib_q[3]}, 5'h02);
        end
        nib_q.delete();
        nrs_q.delete();
`else
        check("rst_ready", oReady === 1'b1, {31'd0, oReady}, 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
`endif
        @(negedge Clock);

        send_chk(8'hA5, 1'b1, 1'b0, 1'b0);
        send_chk(8'hA5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("no_second_xfer", oReady === 1'b1 && oLCD_E === 1'b0,
                  {30'd0, oReady, oLCD_E}, 32'd2);
        end

        send_chk(8'h41, 1'b1, 1'b0, 1'b1);
        send_chk(8'h42, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);

        iData  = 8'h99;
        iRS    = 1'b0;
        iValid = 1'b1;
        @(posedge Clock);
        #1;
        iValid = 1'b0;
        repeat (12) @(negedge Clock);
        check("lo_pulse_e", oLCD_E === 1'b1, {31'd0, oLCD_E}, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("async_e_drop", oLCD_E === 1'b0, {31'd0, oLCD_E}, 32'd0);
`ifndef LCD_INIT_EN
        check("async_ready", oReady === 1'b1, {31'd0, oReady}, 32'd1);
`endif
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        wait_ready("post_rst_ready");
        send_chk(8'h30, 1'b0, 1'b0, 1'b0);

        mon_en = 1;
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge Clock);
            send_raw(8'($urandom), 1'($urandom));
        end
        mon_en = 0;
        check("sb_count", nib_q.size() == 200, nib_q.size(), 200);
        if (nib_q.size() == 200) begin
            for (int i = 0; i < 100; i++) begin
                check($sformatf("sb_%0d", i),
                      {nib_q[2*i], nib_q[2*i+1]} == exp_b[i] &&
                      nrs_q[2*i] == exp_rs[i] && nrs_q[2*i+1] == exp_rs[i],
                      {nrs_q[2*i], nib_q[2*i], nib_q[2*i+1]},
                      {exp_rs[i], exp_b[i]});
            end
        end
        check("rw_zero", rw_bad == 0, rw_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
